// File: rtl/phy_rx_lanes.sv
// Multi-lane serial receive path: per-lane comma alignment and byte
// deserialisation, per-lane deskew FIFOs, and a round-robin unstriper.
module phy_rx_lanes #(
    parameter int         LANES       = 2,
    parameter int         WORD_BYTES  = 4,
    parameter logic [7:0] COMMA       = 8'hBC,
    parameter logic [7:0] IDLE        = 8'h7C,
    parameter int         SYNC_COMMAS = 4,
    parameter int         FIFO_DEPTH  = 4
) (
    input  logic                    clk_32f,
    input  logic                    reset,
    input  logic [LANES-1:0]        data_in,
    input  logic                    sincronizar_bus,
    output logic [8*WORD_BYTES-1:0] data_out,
    output logic                    valid_out,
    output logic                    active,
    output logic [LANES-1:0]        lane_lock,
    output logic                    err_out
);

    localparam int PW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int BW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {SEARCH, ALIGN, LOCKED} lane_state_t;

    logic [LANES-1:0] fifo_empty;
    logic [LANES-1:0] pop_lane;
    logic [LANES-1:0] ovf_lane;
    logic [7:0]       fifo_head [LANES];

    logic [PW-1:0]           p_reg;
    logic [BW-1:0]           b_reg;
    logic [8*WORD_BYTES-1:0] word_reg, word_next, data_reg;
    logic                    active_reg, valid_reg, err_reg, pop;
    logic [7:0]              head_byte;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            lane_state_t   state_reg, state_next;
            logic [7:0]    sr_reg, sr_next;
            logic [2:0]    bit_cnt_reg, bit_cnt_next;
            logic [3:0]    comma_cnt_reg, comma_cnt_next;
            logic          wr_en_reg, wr_en_next;
            logic [7:0]    wr_data_reg, wr_data_next;
            logic [7:0]    mem [FIFO_DEPTH];
            logic [AW-1:0] wptr_reg, rptr_reg;
            logic [CW-1:0] count_reg;
            logic          boundary, full, do_wr;

            // Boundary is the cycle in which the shifted-in bit completes a byte.
            assign sr_next  = {sr_reg[6:0], data_in[gi]};
            assign boundary = (bit_cnt_reg == 3'd7);

            always_ff @(posedge clk_32f or negedge reset) begin
                if (!reset) begin
                    state_reg     <= SEARCH;
                    sr_reg        <= '0;
                    bit_cnt_reg   <= '0;
                    comma_cnt_reg <= '0;
                    wr_en_reg     <= 1'b0;
                    wr_data_reg   <= '0;
                end else begin
                    state_reg     <= state_next;
                    sr_reg        <= sr_next;
                    bit_cnt_reg   <= bit_cnt_next;
                    comma_cnt_reg <= comma_cnt_next;
                    wr_en_reg     <= wr_en_next;
                    wr_data_reg   <= wr_data_next;
                end
            end

            always_comb begin
                state_next     = state_reg;
                bit_cnt_next   = bit_cnt_reg + 3'd1;
                comma_cnt_next = comma_cnt_reg;
                wr_en_next     = 1'b0;
                wr_data_next   = sr_next;
                if (!sincronizar_bus) begin
                    state_next     = SEARCH;
                    comma_cnt_next = '0;
                end else begin
                    case (state_reg)
                        SEARCH: begin
                            if (sr_next == COMMA) begin
                                bit_cnt_next   = '0;
                                comma_cnt_next = 4'd1;
                                state_next     = (SYNC_COMMAS == 1) ? LOCKED : ALIGN;
                            end
                        end
                        ALIGN: begin
                            if (boundary) begin
                                if (sr_next == COMMA) begin
                                    comma_cnt_next = comma_cnt_reg + 4'd1;
                                    if (comma_cnt_reg + 4'd1 == 4'(SYNC_COMMAS))
                                        state_next = LOCKED;
                                end else begin
                                    state_next = SEARCH;
                                end
                            end
                        end
                        LOCKED: begin
                            if (boundary && sr_next != COMMA && sr_next != IDLE)
                                wr_en_next = 1'b1;
                        end
                        default: state_next = SEARCH;
                    endcase
                end
            end

            assign lane_lock[gi] = (state_reg == LOCKED);

            // Deskew FIFO; dropping sincronizar_bus flushes it and discards any pending write.
            assign full           = (count_reg == CW'(FIFO_DEPTH));
            assign do_wr          = wr_en_reg && !full && sincronizar_bus;
            assign ovf_lane[gi]   = wr_en_reg && full && sincronizar_bus;
            assign fifo_empty[gi] = (count_reg == '0);
            assign fifo_head[gi]  = mem[rptr_reg];
            assign pop_lane[gi]   = pop && (p_reg == PW'(gi));

            always_ff @(posedge clk_32f or negedge reset) begin
                if (!reset) begin
                    wptr_reg  <= '0;
                    rptr_reg  <= '0;
                    count_reg <= '0;
                end else if (!sincronizar_bus) begin
                    wptr_reg  <= '0;
                    rptr_reg  <= '0;
                    count_reg <= '0;
                end else begin
                    if (do_wr)
                        wptr_reg <= wptr_reg + AW'(1);
                    if (pop_lane[gi])
                        rptr_reg <= rptr_reg + AW'(1);
                    count_reg <= count_reg + CW'(do_wr) - CW'(pop_lane[gi]);
                end
            end

            always_ff @(posedge clk_32f) begin
                if (do_wr)
                    mem[wptr_reg] <= wr_data_reg;
            end
        end
    endgenerate

    // Unstriper: visit lanes round-robin, filling word slots MSB-first.
    assign pop       = active_reg && sincronizar_bus && !fifo_empty[p_reg];
    assign head_byte = fifo_head[p_reg];

    always_comb begin
        word_next = word_reg;
        for (int k = 0; k < WORD_BYTES; k++) begin
            if (b_reg == BW'(k))
                word_next[8*(WORD_BYTES-1-k) +: 8] = head_byte;
        end
    end

    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            p_reg      <= '0;
            b_reg      <= '0;
            word_reg   <= '0;
            data_reg   <= '0;
            valid_reg  <= 1'b0;
            active_reg <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            active_reg <= &lane_lock;
            err_reg    <= err_reg | (|ovf_lane);
            valid_reg  <= 1'b0;
            if (!active_reg) begin
                p_reg <= '0;
                b_reg <= '0;
            end else if (pop) begin
                word_reg <= word_next;
                p_reg    <= (p_reg == PW'(LANES-1)) ? '0 : p_reg + PW'(1);
                if (b_reg == BW'(WORD_BYTES-1)) begin
                    b_reg     <= '0;
                    data_reg  <= word_next;
                    valid_reg <= 1'b1;
                end else begin
                    b_reg <= b_reg + BW'(1);
                end
            end
        end
    end

    assign data_out  = data_reg;
    assign valid_out = valid_reg;
    assign active    = active_reg;
    assign err_out   = err_reg;

endmodule
